// File: rtl/abft_pkg.sv
// Shared definitions for the ABFT check sequencer: FSM state encoding,
// index/select/counter widths and a saturating increment helper.
package abft_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_MCLR,
        S_MRUN,
        S_WAIT,
        S_NEXT,
        S_DONE
    } abft_seq_state_t;

    localparam int N_IDX  = 4;   // checksum indices checked per run
    localparam int SEL_W  = 2;   // width of each checksum select
    localparam int FCNT_W = 8;   // width of the host fault counter
    localparam int TMR_W  = 8;   // width of the shared cycle timer

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [FCNT_W-1:0] sat_inc(input logic [FCNT_W-1:0] v);
        return (v == '1) ? v : v + FCNT_W'(1);
    endfunction

endpackage

// File: rtl/abft_cyc_timer.sv
// Loadable down-counter used to time the LOAD, MRUN and WAIT phases.
// Ports:
//   clk, rst   clock and asynchronous active-low reset
//   load       reload the counter with load_val this edge
//   load_val   cycles-minus-one for the phase being entered
//   zero       high in the last cycle of the timed phase
module abft_cyc_timer
    import abft_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    output logic             zero
);

    logic [TMR_W-1:0] count;

    // NOTE: clocked state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - TMR_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/abft_check_sequencer.sv
// Sequencing controller for the ABFT checker datapath. Runs the bulk
// accumulators for LOAD_CYC cycles, then for each of four checksum indices
// clears and runs the MAC for CHECK_CYC cycles, waits ERR_LAT cycles and
// samples err_in into fault_map[k].
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   start, abort, clr_cnt    host controls (abort has top priority)
//   err_in                   datapath mismatch flag
//   dp_run, dp_mac_run       datapath run/clear strobes (0 clears)
//   sel_c, sel_r, sel_p      checksum selects, equal to k during checks
//   busy, done               status; done is a one-cycle pulse
//   fault_map, fault_any     per-index mismatch map and its OR
//   fault_cnt                saturating mismatch count across runs
module abft_check_sequencer
    import abft_pkg::*;
#(
    parameter int unsigned LOAD_CYC  = 16,
    parameter int unsigned CHECK_CYC = 4,
    parameter int unsigned ERR_LAT   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              clr_cnt,
    input  logic              err_in,
    output logic              dp_run,
    output logic              dp_mac_run,
    output logic [SEL_W-1:0]  sel_c,
    output logic [SEL_W-1:0]  sel_r,
    output logic [SEL_W-1:0]  sel_p,
    output logic              busy,
    output logic              done,
    output logic [N_IDX-1:0]  fault_map,
    output logic              fault_any,
    output logic [FCNT_W-1:0] fault_cnt
);

    abft_seq_state_t   state_q, state_d;
    logic [SEL_W-1:0]  k_q, k_d;
    logic              tmr_zero, tmr_load;
    logic [TMR_W-1:0]  tmr_val;
    logic              sample, start_ok;
    logic [N_IDX-1:0]  map_d;
    logic [FCNT_W-1:0] cnt_d;
    logic              chk_d;

    abft_cyc_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        sample   = 1'b0;
        start_ok = 1'b0;
        case (state_q)
            S_IDLE:  if (start) begin
                         state_d  = S_CLEAR;
                         start_ok = 1'b1;
                     end
            S_CLEAR: state_d = S_LOAD;
            S_LOAD:  if (tmr_zero) begin
                         state_d = S_MCLR;
                         k_d     = '0;
                     end
            S_MCLR:  state_d = S_MRUN;
            S_MRUN:  if (tmr_zero) state_d = S_WAIT;
            S_WAIT:  if (tmr_zero) begin
                         state_d = S_NEXT;
                         sample  = 1'b1;
                     end
            S_NEXT:  if (k_q == SEL_W'(N_IDX - 1)) begin
                         state_d = S_DONE;
                     end else begin
                         state_d = S_MCLR;
                         k_d     = k_q + SEL_W'(1);
                     end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Abort overrides every transition, including a pending sample.
        if (abort) begin
            state_d  = S_IDLE;
            k_d      = '0;
            sample   = 1'b0;
            start_ok = 1'b0;
        end
    end

    // Timer is reloaded on each state entry with the new phase length.
    always_comb begin
        tmr_load = (state_d != state_q);
        case (state_d)
            S_LOAD:  tmr_val = TMR_W'(LOAD_CYC - 1);
            S_MRUN:  tmr_val = TMR_W'(CHECK_CYC - 1);
            S_WAIT:  tmr_val = TMR_W'(ERR_LAT - 1);
            default: tmr_val = '0;
        endcase
    end

    always_comb begin
        map_d = fault_map;
        cnt_d = fault_cnt;
        if (start_ok) map_d = '0;
        if (sample) begin
            map_d[k_q] = err_in;
            if (err_in) cnt_d = sat_inc(fault_cnt);
        end
        if (clr_cnt) cnt_d = '0;
        chk_d = (state_d inside {S_MCLR, S_MRUN, S_WAIT, S_NEXT});
    end

    // Outputs are registered from the next-state decode so they line up
    // with the state they describe while staying flop-driven.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            k_q        <= '0;
            dp_run     <= 1'b0;
            dp_mac_run <= 1'b0;
            sel_c      <= '0;
            sel_r      <= '0;
            sel_p      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fault_map  <= '0;
            fault_any  <= 1'b0;
            fault_cnt  <= '0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            dp_run     <= !(state_d inside {S_IDLE, S_CLEAR});
            dp_mac_run <= (state_d inside {S_MRUN, S_WAIT, S_NEXT});
            sel_c      <= chk_d ? k_d : '0;
            sel_r      <= chk_d ? k_d : '0;
            sel_p      <= chk_d ? k_d : '0;
            busy       <= (state_d != S_IDLE);
            done       <= (state_d == S_DONE);
            fault_map  <= map_d;
            fault_any  <= |map_d;
            fault_cnt  <= cnt_d;
        end
    end

endmodule

// File: doc/abft_check_sequencer.md
# abft_check_sequencer

Sequencing controller for the lightweight ABFT checker datapath: accumulator bank, checksum muxes, MAC and comparator. Drives the datapath run/clear strobes and the three 2-bit checksum selects through a fixed load-then-check schedule. Samples the datapath error flag once per checksum index and reports a 4-bit fault map, a done pulse and a saturating fault counter to the host.

## Interface
- `LOAD_CYC`, 16: cycles the row, column and product accumulators run during LOAD (1..255).
- `CHECK_CYC`, 4: cycles the MAC and product re-accumulator run per checksum index (1..255).
- `ERR_LAT`, 2: cycles from the end of a check window to a valid `err_in` (1..7).
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begin a run; honoured only in IDLE.
- `abort`  in  1  synchronous abort; any state returns to IDLE next edge.
- `clr_cnt`  in  1  synchronous clear of `fault_cnt`.
- `err_in`  in  1  datapath mismatch flag.
- `dp_run`  out  1  to datapath bulk accumulators; 0 clears them, 1 runs.
- `dp_mac_run`  out  1  to MAC and re-accumulator; 0 clears them, 1 runs.
- `sel_c`, `sel_r`, `sel_p`  out  2 each  column, row and product checksum selects.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at run end.
- `fault_map`  out  4  bit k set if index k mismatched; held until next `start`.
- `fault_any`  out  1  OR of `fault_map`, registered with it.
- `fault_cnt`  out  8  saturating count of mismatching indices across runs.

## Operation
- States: IDLE, CLEAR, LOAD, MCLR, MRUN, WAIT, NEXT, DONE.
- IDLE: `dp_run`=0, `dp_mac_run`=0, selects=0. On `start`, go to CLEAR and zero `fault_map`.
- CLEAR: one cycle with `dp_run`=0, then LOAD.
- LOAD: `dp_run`=1 for exactly `LOAD_CYC` cycles, then MCLR with index k=0. `dp_run` stays 1 until IDLE.
- MCLR: one cycle with `dp_mac_run`=0, then MRUN. Selects already equal k.
- MRUN: `dp_mac_run`=1 for `CHECK_CYC` cycles, then WAIT.
- WAIT: `dp_mac_run`=1, with selects held, for `ERR_LAT` cycles. On the last WAIT cycle, sample `err_in` into `fault_map[k]`. If it is set, increment `fault_cnt`, saturating at 255.
- NEXT: one cycle. If k==3, go to DONE; otherwise k<=k+1 and go to MCLR.
- DONE: `done`=1 for one cycle, then IDLE. Final `fault_map`/`fault_any` are valid in DONE.
- `sel_c`=`sel_r`=`sel_p`=k from MCLR through NEXT. Index k is a 2-bit counter and does not wrap within a run.
- `start` outside IDLE is ignored. `start` in the DONE cycle is ignored; it must be reasserted in IDLE.
- `abort` has priority over every transition. Next state is IDLE, strobes go to 0, `fault_map` is kept, and `done` is not pulsed. `abort` together with `start` in IDLE leaves the block in IDLE.
- `clr_cnt` takes priority over a same-cycle increment: the result is 0.
- Async reset mid-run: immediate IDLE with all outputs at reset values.

## Timing
- Reset values: state IDLE, every output 0, k=0.
- All outputs come from registers; there are no combinational input-to-output paths.
- Run length from the `start` edge to the `done` pulse is 2 + LOAD_CYC + 4·(CHECK_CYC + ERR_LAT + 2) cycles. With default parameters this is 2+16+32 = 50 cycles.
- `busy` rises in the cycle after `start` is sampled. It falls in the cycle after DONE.
- `err_in` is sampled exactly once per index. Values outside that cycle are ignored.

## Structure
- Shared package `abft_pkg`:
  - state enum `abft_seq_state_t`
  - `N_IDX`=4
  - `SEL_W`=2
  - `FCNT_W`=8
- Sub-module `abft_cyc_timer`: a loadable 8-bit down-counter with a `zero` flag. It is reused for the LOAD, MRUN and WAIT durations and is reloaded on every state entry.
- The FSM, index counter, fault map and fault counter stay in the top module.

## Test plan
- Defaults, `err_in` held 0, one `start` → `done` 50 cycles after start, `fault_map`=0000, `fault_cnt`=0. `sel_*` step 0,1,2,3. `dp_mac_run` is low for exactly 4 single cycles.
- `err_in`=1 only in the index-2 sample cycle → `fault_map`=0100, `fault_any`=1, `fault_cnt`=1.
- 64 runs with `err_in` stuck at 1 → `fault_cnt` saturates at 255. Then `clr_cnt` asserted in the same cycle as an increment → `fault_cnt`=0.
- `abort` during MRUN of index 1 → IDLE next cycle, `dp_run`=0, no `done`, `fault_map` holds the index-0 result. A new `start` then completes normally.
- `start` pulsed while busy and in DONE → ignored; exactly one `done` per accepted start.
- Async `rst` low mid-LOAD, then released → all outputs 0 immediately. The next `start` gives a full 50-cycle run.
